// File: rtl/window_pkg.sv
// Shared definitions for the window fetcher: FSM state encoding and
// helpers that derive address/index widths from SIZE and K.
package window_pkg;

    localparam int unsigned DEF_SIZE   = 16;
    localparam int unsigned DEF_K      = 8;
    localparam int unsigned DEF_DATA_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_READ = 2'd1;
    localparam state_t S_LAST = 2'd2;
    localparam state_t S_DONE = 2'd3;

    function automatic int unsigned addr_w(input int unsigned size);
        return $clog2(size);
    endfunction

    function automatic int unsigned idx_w(input int unsigned k);
        return $clog2(k);
    endfunction

endpackage

// File: rtl/window_fetcher_if.sv
// Request / window handshake bundle between the fetcher and its neighbours.
// Optional macro WINDOW_FETCHER_SUM_EN adds the sum_out signal.
interface window_fetcher_if #(
    parameter int unsigned SIZE   = 16,
    parameter int unsigned K      = 8,
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned AW = $clog2(SIZE);

    logic                  start;
    logic [AW-1:0]         addr_in;
    logic                  busy;
    logic [K*DATA_W-1:0]   window_out;
    logic                  valid_out;
    logic                  ready_in;
`ifdef WINDOW_FETCHER_SUM_EN
    logic [DATA_W+$clog2(K)-1:0] sum_out;

    modport master (output start, addr_in, ready_in,
                    input  busy, window_out, valid_out, sum_out);
    modport slave  (input  start, addr_in, ready_in,
                    output busy, window_out, valid_out, sum_out);
`else
    modport master (output start, addr_in, ready_in,
                    input  busy, window_out, valid_out);
    modport slave  (input  start, addr_in, ready_in,
                    output busy, window_out, valid_out);
`endif

endinterface

// File: rtl/window_addr_counter.sv
// Holds the running read address (base + idx, wrapped modulo SIZE) and the
// word index; flags the final index of a window.
module window_addr_counter
    import window_pkg::*;
#(
    parameter int unsigned SIZE = DEF_SIZE,
    parameter int unsigned K    = DEF_K
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_i,
    input  logic [addr_w(SIZE)-1:0]    load_addr_i,
    input  logic                       step_i,
    output logic [addr_w(SIZE)-1:0]    addr_o,
    output logic [idx_w(K)-1:0]        idx_o,
    output logic                       last_o
);
    localparam int unsigned AW = addr_w(SIZE);
    localparam int unsigned IW = idx_w(K);

    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] idx_q,  idx_d;

    assign addr_o = addr_q;
    assign idx_o  = idx_q;
    assign last_o = (idx_q == IW'(K - 1));

    // Next address/index: load restarts at the new base, step advances with natural AW-bit wrap
    always_comb begin
        addr_d = addr_q;
        idx_d  = idx_q;
        if (load_i) begin
            addr_d = load_addr_i;
            idx_d  = '0;
        end else if (step_i) begin
            addr_d = addr_q + 1'b1;
            idx_d  = last_o ? '0 : idx_q + 1'b1;
        end
    end

    // Address/index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            idx_q  <= '0;
        end else begin
            addr_q <= addr_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/window_fetcher.sv
// Fetches K consecutive words (wrapping modulo SIZE) from a synchronous-read
// memory and presents them as one window with a valid/ready handshake.
// Optional macro WINDOW_FETCHER_SUM_EN adds a running sum of the window.
module window_fetcher
    import window_pkg::*;
#(
    parameter int unsigned SIZE   = DEF_SIZE,
    parameter int unsigned K      = DEF_K,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    window_fetcher_if.slave          bus,
    output logic                     mem_rd,
    output logic [addr_w(SIZE)-1:0]  mem_addr,
    input  logic [DATA_W-1:0]        mem_data
);
    localparam int unsigned AW = addr_w(SIZE);
    localparam int unsigned IW = idx_w(K);

    state_t              state_q, state_d;
    logic                load;
    logic                step;
    logic                last;
    logic [IW-1:0]       idx;
    logic                rd_q;
    logic [IW-1:0]       slot_q;
    logic [K*DATA_W-1:0] window_q;

    assign step           = (state_q == S_READ);
    assign mem_rd         = step;
    assign bus.busy       = (state_q == S_READ) || (state_q == S_LAST);
    assign bus.valid_out  = (state_q == S_DONE);
    assign bus.window_out = window_q;

    window_addr_counter #(
        .SIZE (SIZE),
        .K    (K)
    ) u_addr_counter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .load_addr_i (bus.addr_in),
        .step_i      (step),
        .addr_o      (mem_addr),
        .idx_o       (idx),
        .last_o      (last)
    );

    // Next-state decode; a start seen in DONE together with ready chains straight into READ
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (last) state_d = S_LAST;
            end
            S_LAST: state_d = S_DONE;
            S_DONE: begin
                if (bus.ready_in) begin
                    if (bus.start) begin
                        load    = 1'b1;
                        state_d = S_READ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Capture: data for issue idx=i arrives one cycle later, so the issue flag and index are delayed once
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= 1'b0;
            slot_q   <= '0;
            window_q <= '0;
        end else begin
            rd_q   <= step;
            slot_q <= idx;
            for (int unsigned i = 0; i < K; i++) begin
                if (rd_q && (slot_q == IW'(i)))
                    window_q[i*DATA_W +: DATA_W] <= mem_data;
            end
        end
    end

`ifdef WINDOW_FETCHER_SUM_EN
    localparam int unsigned SW = DATA_W + $clog2(K);
    logic [SW-1:0] sum_q;

    assign bus.sum_out = sum_q;

    // Running sum of captured words, restarted on every accepted request
    always_ff @(posedge clk) begin
        if (rst)       sum_q <= '0;
        else if (load) sum_q <= '0;
        else if (rd_q) sum_q <= sum_q + SW'(mem_data);
    end
`endif

endmodule

// File: tb/tb_window_fetcher.sv
// Directed bench for window_fetcher (SIZE=16, K=8, DATA_W=16) against a
// synchronous-read memory model holding mem[a] = 16'h0100 + a.
module tb_window_fetcher;
    import window_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data = 16'h0000;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    window_fetcher_if #(.SIZE(16), .K(8), .DATA_W(16)) bus ();

    window_fetcher #(.SIZE(16), .K(8), .DATA_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, poison value when not reading
    always @(posedge clk) begin
        if (mem_rd) mem_data <= 16'h0100 + {12'h000, mem_addr};
        else        mem_data <= 16'hDEAD;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the edge that accepted a request; follows the fetch to DONE
    task automatic wait_valid(input string tag, input logic [3:0] base,
                              input int unsigned glitch_at,
                              input logic [127:0] exp_win, input logic [18:0] exp_sum);
        int unsigned t = 1;
        int unsigned rd_cnt = 0;
        int unsigned addr_err = 0;
        logic [3:0]  ea;
        while (!bus.valid_out && t < 30) begin
            if (mem_rd) begin
                ea = base + 4'(rd_cnt);
                if (mem_addr !== ea) addr_err++;
                rd_cnt++;
            end
            bus.start   = (t == glitch_at);
            bus.addr_in = (t == glitch_at) ? 4'd3 : 4'd0;
            tick();
            t++;
        end
        bus.start   = 1'b0;
        bus.addr_in = 4'd0;
        check({tag, "_valid"},    128'(bus.valid_out), 128'd1);
        check({tag, "_latency"},  128'(t), 128'd10);
        check({tag, "_rd_cycles"}, 128'(rd_cnt), 128'd8);
        check({tag, "_addr_seq"}, 128'(addr_err), 128'd0);
        check({tag, "_window"},   bus.window_out, exp_win);
        check({tag, "_busy"},     128'(bus.busy), 128'd0);
`ifdef WINDOW_FETCHER_SUM_EN
        check({tag, "_sum"},      128'(bus.sum_out), 128'(exp_sum));
`endif
    endtask

    initial begin
        logic [127:0] held;
        int unsigned  stable_err;

        bus.start    = 1'b0;
        bus.addr_in  = 4'd0;
        bus.ready_in = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy",   128'(bus.busy), 128'd0);
        check("rst_mem_rd", 128'(mem_rd), 128'd0);
        check("rst_addr",   128'(mem_addr), 128'd0);
        check("rst_valid",  128'(bus.valid_out), 128'd0);
        check("rst_window", bus.window_out, 128'd0);
        rst = 1'b0;
        tick();

        // Fetch from address 0
        bus.start = 1'b1; bus.addr_in = 4'd0;
        tick();
        bus.start = 1'b0;
        check("a0_first_rd", 128'(mem_rd), 128'd1);
        wait_valid("a0", 4'd0, 0,
                   128'h0107_0106_0105_0104_0103_0102_0101_0100, 19'h0081C);
        bus.ready_in = 1'b1;
        tick();
        bus.ready_in = 1'b0;
        check("a0_release", 128'(bus.valid_out), 128'd0);
        tick();

        // Wrapping fetch from 14, with an ignored start pulse during READ
        bus.start = 1'b1; bus.addr_in = 4'd14;
        tick();
        bus.start = 1'b0;
        wait_valid("a14", 4'd14, 3,
                   128'h0105_0104_0103_0102_0101_0100_010F_010E, 19'h0082C);

        // Hold in DONE with ready low; a start pulse there must be ignored
        held = bus.window_out;
        stable_err = 0;
        for (int k = 0; k < 5; k++) begin
            bus.start   = (k == 2);
            bus.addr_in = (k == 2) ? 4'd7 : 4'd0;
            tick();
            if (bus.valid_out !== 1'b1 || bus.window_out !== held || mem_rd !== 1'b0)
                stable_err++;
        end
        bus.start = 1'b0; bus.addr_in = 4'd0;
        check("hold_stable", 128'(stable_err), 128'd0);

        // Back-to-back: ready and start together in DONE
        bus.ready_in = 1'b1; bus.start = 1'b1; bus.addr_in = 4'd10;
        tick();
        bus.ready_in = 1'b0; bus.start = 1'b0; bus.addr_in = 4'd0;
        check("b2b_rd",   128'(mem_rd), 128'd1);
        check("b2b_addr", 128'(mem_addr), 128'd10);
        wait_valid("a10", 4'd10, 0,
                   128'h0101_0100_010F_010E_010D_010C_010B_010A, 19'h0084C);
        bus.ready_in = 1'b1;
        tick();
        bus.ready_in = 1'b0;
        tick();

        // Reset during the 4th READ cycle
        bus.start = 1'b1; bus.addr_in = 4'd2;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("mid_in_read", 128'(mem_rd), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy",   128'(bus.busy), 128'd0);
        check("mid_mem_rd", 128'(mem_rd), 128'd0);
        check("mid_addr",   128'(mem_addr), 128'd0);
        check("mid_valid",  128'(bus.valid_out), 128'd0);
        check("mid_window", bus.window_out, 128'd0);
        for (int k = 0; k < 12; k++) tick();
        check("mid_no_partial", 128'(bus.valid_out), 128'd0);

        // Clean fetch after the abort
        bus.start = 1'b1; bus.addr_in = 4'd4;
        tick();
        bus.start = 1'b0;
        wait_valid("a4", 4'd4, 0,
                   128'h010B_010A_0109_0108_0107_0106_0105_0104, 19'h0083C);
        bus.ready_in = 1'b1;
        tick();
        bus.ready_in = 1'b0;
        check("a4_release", 128'(bus.valid_out), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/window_fetcher.md
Name: window_fetcher

Overview:
- Downstream consumer of the consecutive-address generator: takes a start address and fetches the K consecutive words of a SIZE-entry memory, wrapping modulo SIZE.
- Issues one synchronous read per cycle and packs the returned words into a window register.
- Presents the window with a valid/ready handshake to the next stage.
- Bridges the combinational address generator to the registered data path.

Parameters:
- SIZE, 16, memory depth; must be a power of two; address width AW = $clog2(SIZE).
- K, 8, window length (words per fetch); 2 <= K <= SIZE.
- DATA_W, 16, memory word width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when accepted (see Behaviour).
- addr_in  input  AW  start address, captured with start.
- busy  output  1  high in READ and LAST states.
- mem_rd  output  1  read strobe to memory.
- mem_addr  output  AW  read address (registered).
- mem_data  input  DATA_W  read data, valid exactly one cycle after mem_rd.
- window_out  output  K*DATA_W  fetched words; slot i = bits [i*DATA_W +: DATA_W] = mem[(addr_in+i) mod SIZE].
- valid_out  output  1  window_out is complete and stable.
- ready_in  input  1  downstream accepts the window.

Behaviour:
- Reset (synchronous, active-high, on the clk edge): state IDLE; busy=0, mem_rd=0, mem_addr=0, valid_out=0, window_out=0, index counter=0.
- Reset mid-fetch aborts with no partial output. Reset has priority over every other input.
- FSM states:
  - IDLE: start=1 captures addr_in into base; next state READ.
  - READ: mem_rd=1, mem_addr=(base+idx) mod SIZE, idx increments 0..K-1. After issuing idx=K-1, next state LAST.
  - LAST: mem_rd=0; captures the final word; next state DONE.
  - DONE: valid_out=1, window_out held. When ready_in=1, leave DONE. If start=1 in the same cycle, the new request is accepted (back-to-back) and the next state is READ; otherwise the next state is IDLE.
- Data capture: the word returned in the cycle after the idx=i issue is written to slot i.
- Latency: start sampled at edge n; mem_rd is high for cycles n+1..n+K; valid_out rises at edge n+K+2.
- Address wrap: natural AW-bit overflow, so base=14, K=8 reads addresses 14,15,0,1,...,5.
- start in READ or LAST is ignored (not queued). addr_in is ignored except when start is accepted.
- window_out changes only during capture cycles. It is never modified while valid_out=1.
- valid_out stays high until ready_in; ready_in in non-DONE states has no effect.

Optional Feature:
- Macro: WINDOW_FETCHER_SUM_EN.
- Defined:
  - Extra output sum_out, width DATA_W+$clog2(K), unsigned.
  - Cleared on start acceptance and on reset; accumulates each captured word.
  - Final sum is valid and stable while valid_out=1.
- Undefined: port and accumulator absent; all other behaviour identical.

Decomposition:
- Shared package (window_pkg):
  - FSM state typedef {IDLE, READ, LAST, DONE}, 2-bit encoding.
  - AW/index-width helper constants derived from SIZE and K.
- One natural sub-module, window_addr_counter: holds base and idx, outputs mem_addr (wrapped) and a last flag. The FSM and capture logic stay in the top.

Test Plan:
- Memory model mem[a]=16'h0100+a. Start with addr_in=0 -> mem_rd high 8 cycles on addresses 0..7; valid_out at start+10; slot i = 16'h0100+i.
- Start with addr_in=14 -> addresses 14,15,0..5; slots {010E,010F,0100..0105}. No out-of-range address is ever driven.
- Hold ready_in=0 for 5 cycles in DONE -> valid_out and window_out stable. A start pulse during READ and during DONE (with ready_in=0) is ignored.
- In DONE, ready_in=1 and start=1 with addr_in=10 in the same cycle -> next cycle READ at address 10, no IDLE cycle. Second window = 010A..010F,0100,0101.
- Assert rst at the 4th READ cycle -> next cycle all outputs 0 and state IDLE. A following fetch with addr_in=4 returns a correct, uncorrupted window.
- WINDOW_FETCHER_SUM_EN defined, addr_in=0 -> sum_out=0x0800+28=0x081C while valid_out=1.
